mc_control_unit: RTL and testbench

Multicycle main controller for the RV32I core: a Moore-style FSM that sequences the shared datapath (PC, instruction/data memory port, register file, ALU) one micro-step per cycle. It decodes the held instruction fields and drives every datapath select and write enable. It also drives the ALU operation code (`ALUop_t`), sharing the single ALU between PC increment, address generation, branch compare and execute. It sits between the instruction register and the datapath mux/enable inputs.

---
 rtl/DataTypes_pkg.sv | 71 +++++++
 rtl/alu_decoder.sv | 44 ++++
 rtl/mc_control_unit.sv | 185 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/DataTypes_pkg.sv
// Shared types for the multicycle RV32I core: ALU operation codes, controller
// state encoding, opcode constants and the immediate-format helper.
package DataTypes_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_SrB  = 4'd10
    } ALUop_t;

    // Coarse ALU intent chosen by the FSM, refined by alu_decoder
    typedef enum logic [1:0] {
        ALUCLS_ADD    = 2'd0,
        ALUCLS_BRANCH = 2'd1,
        ALUCLS_FUNCT  = 2'd2,
        ALUCLS_SRB    = 2'd3
    } alu_class_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_LUI      = 4'd8,
        S_JALRADR  = 4'd9,
        S_JAL      = 4'd10,
        S_BRANCH   = 4'd11,
        S_ALUWB    = 4'd12
    } ctrl_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] fmt;
        case (op)
            OP_STORE:          fmt = IMM_S;
            OP_BRANCH:         fmt = IMM_B;
            OP_JAL:            fmt = IMM_J;
            OP_LUI, OP_AUIPC:  fmt = IMM_U;
            default:           fmt = IMM_I;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select: maps the FSM's ALU class plus the
// instruction function fields to a concrete ALUop_t.
module alu_decoder
    import DataTypes_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        op5,
    output ALUop_t      alu_op
);

    // Branch compares reuse SUB/SLT/SLTU so the Zero flag encodes the outcome
    always_comb begin
        alu_op = ALU_ADD;
        case (alu_class)
            ALUCLS_ADD: alu_op = ALU_ADD;
            ALUCLS_SRB: alu_op = ALU_SrB;
            ALUCLS_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_ADD;
                endcase
            end
            ALUCLS_FUNCT: begin
                case (funct3)
                    3'b000:  alu_op = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I main controller: Moore FSM sequencing the shared datapath
// one micro-step per cycle; only branch PCWrite looks at Zero combinationally.
module mc_control_unit
    import DataTypes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output ALUop_t      ALUControl,
    output logic        RegWrite,
    output logic        IllegalInstr
);

    ctrl_state_t state_r;
    ctrl_state_t state_next_s;
    alu_class_t  alu_class_s;
    logic        known_op_s;
    logic        illegal_s;
    logic        taken_s;
    logic        pc_write_s;
    logic        ir_write_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic        illegal_pulse_s;

    // Opcode legality, including the two unassigned branch funct3 codes
    always_comb begin
        case (op)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: known_op_s = 1'b1;
            default:                              known_op_s = 1'b0;
        endcase
        illegal_s = ~known_op_s | ((op == OP_BRANCH) & (funct3[2:1] == 2'b01));
    end

    // beq/bge/bgeu take on Zero, bne/blt/bltu on !Zero
    assign taken_s = Zero ^ (funct3[0] ^ funct3[2]);

    // Next-state selection
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_FETCH:    state_next_s = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (illegal_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
                        OP_R:              state_next_s = S_EXECR;
                        OP_I:              state_next_s = S_EXECI;
                        OP_LUI:            state_next_s = S_LUI;
                        OP_AUIPC:          state_next_s = S_ALUWB;
                        OP_JAL:            state_next_s = S_JAL;
                        OP_JALR:           state_next_s = S_JALRADR;
                        OP_BRANCH:         state_next_s = S_BRANCH;
                        default:           state_next_s = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_next_s = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next_s = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next_s = S_FETCH;
            S_MEMWRITE: state_next_s = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_next_s = S_ALUWB;
            S_EXECI:    state_next_s = S_ALUWB;
            S_LUI:      state_next_s = S_ALUWB;
            S_JALRADR:  state_next_s = S_JAL;
            S_JAL:      state_next_s = S_ALUWB;
            S_BRANCH:   state_next_s = S_FETCH;
            S_ALUWB:    state_next_s = S_FETCH;
            default:    state_next_s = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Per-state datapath selects and raw enables
    always_comb begin
        AdrSrc          = 1'b0;
        ResultSrc       = 2'b00;
        ALUSrcA         = 2'b00;
        ALUSrcB         = 2'b00;
        ImmSrc          = IMM_I;
        alu_class_s     = ALUCLS_ADD;
        pc_write_s      = 1'b0;
        ir_write_s      = 1'b0;
        mem_write_s     = 1'b0;
        reg_write_s     = 1'b0;
        illegal_pulse_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                ResultSrc  = 2'b10;
                ALUSrcB    = 2'b10;
                pc_write_s = MemReady;
                ir_write_s = MemReady;
            end
            S_DECODE: begin
                ALUSrcA         = 2'b01;
                ALUSrcB         = 2'b01;
                ImmSrc          = imm_src_of(op);
                illegal_pulse_s = illegal_s;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_src_of(op);
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA     = 2'b10;
                alu_class_s = ALUCLS_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b01;
                alu_class_s = ALUCLS_FUNCT;
            end
            S_LUI: begin
                ALUSrcB     = 2'b01;
                ImmSrc      = IMM_U;
                alu_class_s = ALUCLS_SRB;
            end
            S_JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 2'b10;
                alu_class_s = ALUCLS_BRANCH;
                pc_write_s  = taken_s;
            end
            S_ALUWB:    reg_write_s = 1'b1;
            default:    ALUSrcB = 2'b10;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class (alu_class_s),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .op5       (op[5]),
        .alu_op    (ALUControl)
    );

    // Enables drop the instant reset asserts, even mid-instruction
    assign PCWrite      = pc_write_s & rst_n;
    assign IRWrite      = ir_write_s & rst_n;
    assign MemWrite     = mem_write_s & rst_n;
    assign RegWrite     = reg_write_s & rst_n;
    assign IllegalInstr = illegal_pulse_s & rst_n;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench: each instruction is expanded into a list of expected
// micro-steps from the ISA-level rules, then replayed cycle by cycle.
module tb_mc_control_unit;
    import DataTypes_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc;
    ALUop_t      ALUControl;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       mr;
        logic       zero;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] alu;
        logic       rw;
        logic       ill;
        logic       imm_care;
        logic [2:0] imm;
    } step_t;

    step_t q[$];

    mc_control_unit dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .IllegalInstr(IllegalInstr)
    );

    always #5 clk = ~clk;

    function automatic step_t idle();
        step_t s = '0;
        s.alu  = ALU_ADD;
        s.mr   = 1'($urandom);
        s.zero = 1'($urandom);
        return s;
    endfunction

    function automatic step_t fetch_step(input logic ready);
        step_t s = idle();
        s.mr  = ready;
        s.pcw = ready;
        s.irw = ready;
        s.rs  = 2'b10;
        s.sb  = 2'b10;
        return s;
    endfunction

    function automatic logic legal(input logic [6:0] o, input logic [2:0] f3);
        if (o == OP_BRANCH) return (f3 != 3'd2) && (f3 != 3'd3);
        return o inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_AUIPC,
                         OP_JAL, OP_JALR};
    endfunction

    function automatic logic [2:0] fmt(input logic [6:0] o);
        if (o == OP_STORE) return 3'd1;
        if (o == OP_BRANCH) return 3'd2;
        if (o == OP_JAL) return 3'd3;
        if (o == OP_LUI || o == OP_AUIPC) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [3:0] exp_funct(input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7);
        ALUop_t tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                            ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (f3 == 3'd0 && o == OP_R && f7) return ALU_SUB;
        if (f3 == 3'd5 && f7) return ALU_SRA;
        return tbl[f3];
    endfunction

    // Expected micro-steps for one instruction; a/b are the branch operands
    task automatic plan(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input int fstall, input int mstall,
                        input logic [31:0] a, input logic [31:0] b);
        step_t s;
        for (int i = 0; i < fstall; i++) q.push_back(fetch_step(1'b0));
        q.push_back(fetch_step(1'b1));
        s = idle(); s.sa = 2'b01; s.sb = 2'b01; s.imm_care = 1'b1; s.imm = fmt(o);
        s.ill = !legal(o, f3);
        q.push_back(s);
        if (!legal(o, f3)) return;
        if (o == OP_LOAD || o == OP_STORE) begin
            s = idle(); s.sa = 2'b10; s.sb = 2'b01; s.imm_care = 1'b1; s.imm = fmt(o);
            q.push_back(s);
            for (int i = 0; i <= mstall; i++) begin
                s = idle(); s.adr = 1'b1; s.mr = (i == mstall);
                s.memw = (o == OP_STORE);
                q.push_back(s);
            end
            if (o == OP_LOAD) begin
                s = idle(); s.rs = 2'b01; s.rw = 1'b1; q.push_back(s);
            end
            return;
        end
        if (o == OP_BRANCH) begin
            s = idle(); s.sa = 2'b10; s.sb = 2'b00;
            case (f3[2:1])
                2'b00:   begin s.alu = ALU_SUB;  s.zero = (a == b); end
                2'b10:   begin s.alu = ALU_SLT;  s.zero = !($signed(a) < $signed(b)); end
                default: begin s.alu = ALU_SLTU; s.zero = !(a < b); end
            endcase
            case (f3)
                3'd0:    s.pcw = (a == b);
                3'd1:    s.pcw = (a != b);
                3'd4:    s.pcw = ($signed(a) < $signed(b));
                3'd5:    s.pcw = ($signed(a) >= $signed(b));
                3'd6:    s.pcw = (a < b);
                default: s.pcw = (a >= b);
            endcase
            q.push_back(s);
            return;
        end
        if (o == OP_R || o == OP_I) begin
            s = idle(); s.sa = 2'b10; s.sb = (o == OP_I) ? 2'b01 : 2'b00;
            s.alu = exp_funct(o, f3, f7);
            q.push_back(s);
        end
        if (o == OP_LUI) begin
            s = idle(); s.sb = 2'b01; s.alu = ALU_SrB; s.imm_care = 1'b1; s.imm = 3'd4;
            q.push_back(s);
        end
        if (o == OP_JALR) begin
            s = idle(); s.sa = 2'b10; s.sb = 2'b01; q.push_back(s);
        end
        if (o == OP_JAL || o == OP_JALR) begin
            s = idle(); s.sa = 2'b01; s.sb = 2'b10; s.pcw = 1'b1; q.push_back(s);
        end
        s = idle(); s.rw = 1'b1; q.push_back(s);
    endtask

    task automatic check(input step_t s, input string tag);
        logic [15:0] got, want;
        got  = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, RegWrite, IllegalInstr};
        want = {s.pcw, s.adr, s.memw, s.irw, s.rs, s.sa, s.sb, s.alu, s.rw, s.ill};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s outputs: got %h expected %h", tag, got, want);
        end
        if (s.imm_care) begin
            checks++;
            assert (ImmSrc === s.imm) else begin
                errors++;
                $error("FAIL %s ImmSrc: got %0d expected %0d", tag, ImmSrc, s.imm);
            end
        end
    endtask

    // Replays up to n queued steps, driving inputs on the falling edge
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input int n, input string tag);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            @(negedge clk);
            op = o; funct3 = f3; funct7b5 = f7; MemReady = s.mr; Zero = s.zero;
            #1;
            check(s, $sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int fstall, input int mstall,
                            input logic [31:0] a, input logic [31:0] b, input string tag);
        plan(o, f3, f7, fstall, mstall, a, b);
        run(o, f3, f7, q.size(), tag);
    endtask

    initial begin
        step_t rs;
        logic [6:0] ops [9] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI,
                                OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH};
        logic [6:0] o;
        logic [31:0] a;

        rs = fetch_step(1'b0);
        rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b0;
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        repeat (2) @(negedge clk);
        #1 check(rs, "reset");
        MemReady = 1'b0; rst_n = 1'b1;

        do_instr(OP_R, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0, "add");
        do_instr(OP_R, 3'd0, 1'b1, 0, 0, 32'd0, 32'd0, "sub");
        do_instr(OP_I, 3'd0, 1'b1, 0, 0, 32'd0, 32'd0, "addi_b30");
        do_instr(OP_LOAD, 3'd2, 1'b0, 0, 2, 32'd0, 32'd0, "lw_stall");
        do_instr(OP_BRANCH, 3'd5, 1'b0, 0, 0, 32'd5, 32'd3, "bge_taken");
        do_instr(OP_BRANCH, 3'd5, 1'b0, 0, 0, 32'd1, 32'd9, "bge_not");
        do_instr(OP_JALR, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0, "jalr");
        do_instr(7'h00, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0, "illegal_op");
        do_instr(OP_BRANCH, 3'd3, 1'b0, 1, 0, 32'd0, 32'd0, "illegal_br");
        do_instr(OP_STORE, 3'd2, 1'b0, 2, 1, 32'd0, 32'd0, "sw_stall");
        do_instr(OP_LUI, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0, "lui");

        // Reset while in EXECR: abandon the instruction, enables drop at once
        plan(OP_R, 3'd7, 1'b0, 0, 0, 32'd0, 32'd0);
        run(OP_R, 3'd7, 1'b0, 3, "and_pre_reset");
        q.delete();
        #1 rst_n = 1'b0; MemReady = 1'b1;
        #1 check(rs, "reset_in_execr");
        @(negedge clk);
        #1 check(rs, "reset_held");
        MemReady = 1'b0; rst_n = 1'b1;

        for (int n = 0; n < 60; n++) begin
            o = ($urandom_range(9, 0) == 0) ? 7'($urandom) : ops[$urandom_range(8, 0)];
            a = $urandom;
            do_instr(o, 3'($urandom_range(7, 0)), 1'($urandom),
                     $urandom_range(2, 0), $urandom_range(2, 0), a,
                     ($urandom_range(3, 0) == 0) ? a : 32'($urandom),
                     $sformatf("rnd%0d_op%02h", n, o));
        end
        do_instr(OP_R, 3'd4, 1'b0, 0, 0, 32'd0, 32'd0, "xor_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
